// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Ceiling log2, never less than 1 so a counter always has at least one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 16; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// WIDTH-bit load/shift register; exposes the bit currently at the output end.
module piso_shift_reg #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             sbit
);

    logic [WIDTH-1:0] shreg_reg;
    logic [WIDTH-1:0] shreg_next;
    logic [WIDTH-1:0] shifted;

    // Each bit takes its neighbour away from the output end; the far end fills with 0.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (MSB_FIRST) begin : g_left
                if (gi == 0) begin : g_fill
                    assign shifted[gi] = 1'b0;
                end else begin : g_take
                    assign shifted[gi] = shreg_reg[gi-1];
                end
            end else begin : g_right
                if (gi == WIDTH - 1) begin : g_fill
                    assign shifted[gi] = 1'b0;
                end else begin : g_take
                    assign shifted[gi] = shreg_reg[gi+1];
                end
            end
        end

        if (MSB_FIRST) begin : g_out_msb
            assign sbit = shreg_reg[WIDTH-1];
        end else begin : g_out_lsb
            assign sbit = shreg_reg[0];
        end
    endgenerate

    always_comb begin
        shreg_next = shreg_reg;
        if (load) begin
            shreg_next = din;
        end else if (shift) begin
            shreg_next = shifted;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_reg <= '0;
        end else begin
            shreg_reg <= shreg_next;
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// Serializer top: valid/ready word intake, bit counter and IDLE/SHIFT FSM.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             done,
    output logic             busy
);

    localparam int            CW   = clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t        state_reg;
    logic [CW-1:0] cnt_reg;
    logic          last_bit;
    logic          handshake;
    logic          sbit;

    assign last_bit   = (state_reg == SHIFT) && (cnt_reg == LAST);
    assign load_ready = (state_reg == IDLE) || last_bit;
    assign handshake  = load_valid && load_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (handshake) begin
                        state_reg <= SHIFT;
                        cnt_reg   <= '0;
                    end
                end
                SHIFT: begin
                    if (last_bit) begin
                        // A word accepted on the last bit follows with no gap.
                        state_reg <= handshake ? SHIFT : IDLE;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    piso_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shreg (
        .clk   (clk),
        .reset (reset),
        .load  (handshake),
        .shift (state_reg == SHIFT),
        .din   (load_data),
        .sbit  (sbit)
    );

    assign busy        = (state_reg == SHIFT);
    assign sout_valid  = busy;
    assign sout        = busy ? sbit : IDLE_LEVEL;
    assign frame_start = busy && (cnt_reg == '0);
    assign done        = last_bit;

endmodule

// File: tb/tb_piso_serializer.sv
// Randomized and directed bench for piso_serializer against a queue-of-bits model.
module tb_piso_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         load_valid = 1'b0;
    logic [W-1:0] load_data = '0;

    logic ready_m, sout_m, sval_m, fs_m, done_m, busy_m;
    logic ready_l, sout_l, sval_l, fs_l, done_l, busy_l;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_msb (
        .clk         (clk),
        .reset       (reset),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_ready  (ready_m),
        .sout        (sout_m),
        .sout_valid  (sval_m),
        .frame_start (fs_m),
        .done        (done_m),
        .busy        (busy_m)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_lsb (
        .clk         (clk),
        .reset       (reset),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_ready  (ready_l),
        .sout        (sout_l),
        .sout_valid  (sval_l),
        .frame_start (fs_l),
        .done        (done_l),
        .busy        (busy_l)
    );

    // Model: every accepted word becomes W queued bits; the head is the bit on the wire now.
    typedef struct packed {
        logic b;
        logic first;
        logic last;
    } ebit_t;

    ebit_t q_m[$];
    ebit_t q_l[$];

    int unsigned  vectors = 0;
    int unsigned  miscompares = 0;
    logic [W-1:0] cap_m, cap_l;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic ev_m, ev_l;
        ev_m = (q_m.size() > 0);
        ev_l = (q_l.size() > 0);
        check_eq("msb_sout_valid", sval_m, ev_m);
        check_eq("msb_busy", busy_m, ev_m);
        check_eq("msb_sout", sout_m, ev_m ? q_m[0].b : 1'b0);
        check_eq("msb_frame_start", fs_m, ev_m ? q_m[0].first : 1'b0);
        check_eq("msb_done", done_m, ev_m ? q_m[0].last : 1'b0);
        check_eq("msb_load_ready", ready_m, q_m.size() <= 1);
        check_eq("lsb_sout_valid", sval_l, ev_l);
        check_eq("lsb_busy", busy_l, ev_l);
        check_eq("lsb_sout", sout_l, ev_l ? q_l[0].b : 1'b1);
        check_eq("lsb_frame_start", fs_l, ev_l ? q_l[0].first : 1'b0);
        check_eq("lsb_done", done_l, ev_l ? q_l[0].last : 1'b0);
        check_eq("lsb_load_ready", ready_l, q_l.size() <= 1);
    endtask

    // One clock: check at the falling edge, drive, then advance the model at the rising edge.
    task automatic step(input logic rst, input logic vld, input logic [W-1:0] d,
                        input bit chk, output bit accepted);
        bit ready_now;
        @(negedge clk);
        if (chk) begin
            check_outputs();
            if (sval_m === 1'b1) cap_m = {cap_m[W-2:0], sout_m};
            if (sval_l === 1'b1) cap_l = {sout_l, cap_l[W-1:1]};
        end
        reset      = rst;
        load_valid = vld;
        load_data  = d;
        ready_now  = (q_m.size() <= 1);
        accepted   = vld && ready_now && !rst;
        @(posedge clk);
        if (rst) begin
            q_m.delete();
            q_l.delete();
        end else begin
            if (q_m.size() > 0) void'(q_m.pop_front());
            if (q_l.size() > 0) void'(q_l.pop_front());
            if (accepted) begin
                for (int i = 0; i < W; i++) begin
                    q_m.push_back('{b: d[W-1-i], first: (i == 0), last: (i == W-1)});
                    q_l.push_back('{b: d[i],     first: (i == 0), last: (i == W-1)});
                end
            end
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, W'($urandom), 1'b1, acc);
    endtask

    // Hold load_valid and data stable until the model says the word was taken.
    task automatic send_word(input logic [W-1:0] d);
        bit acc;
        int tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 3 * W) begin
            step(1'b0, 1'b1, d, 1'b1, acc);
            tries++;
        end
        if (!acc) check_eq("accept_timeout", 0, 1);
    endtask

    initial begin
        bit           acc;
        bit           pend;
        logic [W-1:0] pw;
        logic         rst;

        // Reset held two cycles, then idle.
        step(1'b1, 1'b1, 8'h5A, 1'b0, acc);
        step(1'b1, 1'b1, 8'h5A, 1'b1, acc);
        idle(5);

        // Single word A5 on both instances.
        cap_m = '0;
        cap_l = '0;
        send_word(8'hA5);
        idle(W + 2);
        check_eq("msb_word_A5", cap_m, 8'hA5);
        check_eq("lsb_word_A5", cap_l, 8'hA5);

        // LSB-first single bit pattern.
        cap_m = '0;
        cap_l = '0;
        send_word(8'h01);
        idle(W + 2);
        check_eq("lsb_word_01", cap_l, 8'h01);
        check_eq("msb_word_01", cap_m, 8'h01);

        // Back-to-back with load_valid held high.
        send_word(8'hFF);
        send_word(8'h00);
        idle(W + 2);

        // Hold-off: new word offered during bit 3.
        send_word(8'h96);
        idle(2);
        send_word(8'h3C);
        idle(W + 2);

        // Reset on bit 4 aborts the word.
        send_word(8'hF0);
        idle(3);
        step(1'b1, 1'b0, 8'h00, 1'b1, acc);
        idle(3);

        // Reset with load_valid in the same cycle: nothing accepted.
        step(1'b1, 1'b1, 8'hC3, 1'b1, acc);
        idle(3);

        // Randomized traffic with occasional resets.
        pend = 1'b0;
        pw   = '0;
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 79) == 0);
            if (!pend && $urandom_range(0, 3) != 0) begin
                pend = 1'b1;
                pw   = W'($urandom);
            end
            step(rst, pend, pend ? pw : W'($urandom), 1'b1, acc);
            if (acc) pend = 1'b0;
        end
        idle(W + 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
